// File: rtl/glb_responder_if.sv
// GLB access channel: arbitrated read and write requests toward the global buffer.
// Latency: read data returns one cycle after the read is accepted.
// Backpressure: per-direction ready; a request counts only when its ready is high.
interface glb_responder_if #(
    parameter int ADDR_W = 32
) ();
    logic              glb_read_i;
    logic [ADDR_W-1:0] glb_read_addr_i;
    logic              glb_read_ready_o;
    logic [31:0]       glb_read_data_o;
    logic              glb_read_valid_o;
    logic              glb_write_i;
    logic [ADDR_W-1:0] glb_write_addr_i;
    logic [3:0]        glb_write_web_i;
    logic [31:0]       glb_write_data_i;
    logic              glb_write_ready_o;

    // Requester side (token engine arbiter)
    modport master (
        output glb_read_i, glb_read_addr_i,
        input  glb_read_ready_o, glb_read_data_o, glb_read_valid_o,
        output glb_write_i, glb_write_addr_i, glb_write_web_i, glb_write_data_i,
        input  glb_write_ready_o
    );

    // Responder side (global buffer)
    modport slave (
        input  glb_read_i, glb_read_addr_i,
        output glb_read_ready_o, glb_read_data_o, glb_read_valid_o,
        input  glb_write_i, glb_write_addr_i, glb_write_web_i, glb_write_data_i,
        output glb_write_ready_o
    );
endinterface

// File: rtl/glb_responder.sv
// Global buffer responder: single-port word memory fronted by a one-entry write buffer.
// Latency: read data/valid one cycle after acceptance; writes drain on read-free cycles.
// Backpressure: read_ready drops for one cycle on a forced drain; write_ready drops while the buffer is full and a read wins the port.
module glb_responder #(
    parameter int DEPTH       = 16384,
    parameter int ADDR_W      = 32,
    parameter int DRAIN_LIMIT = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    glb_responder_if.slave        glb,
    output logic                  busy_o,
    output logic                  addr_err_o
);
    localparam int              IDX_W     = ADDR_W - 2;
    localparam int              MEM_AW    = $clog2(DEPTH);
    localparam logic [IDX_W-1:0] DEPTH_IDX = IDX_W'(DEPTH);
    localparam logic [3:0]      LIMIT     = 4'(DRAIN_LIMIT);

    logic [31:0] mem [DEPTH];

    // Write buffer and stall tracking
    logic              wb_valid_q, wb_valid_d;
    logic [MEM_AW-1:0] wb_idx_q,   wb_idx_d;
    logic [31:0]       wb_data_q,  wb_data_d;
    logic [3:0]        wb_web_q,   wb_web_d;
    logic [3:0]        stall_cnt_q, stall_cnt_d;

    // Read return path: raw memory word plus the forwarded bytes captured at acceptance
    logic [31:0]       mem_rdata_q;
    logic [3:0]        fwd_mask_q, fwd_mask_d;
    logic [31:0]       fwd_data_q, fwd_data_d;
    logic              rd_zero_q,  rd_zero_d;
    logic              rd_valid_q;
    logic              addr_err_q, addr_err_d;

    logic [IDX_W-1:0]  rd_idx, wr_idx;
    logic              rd_in_range, wr_in_range;
    logic              force_drain, rd_acc, wr_acc, drain, wr_capture;

    assign rd_idx      = glb.glb_read_addr_i[ADDR_W-1:2];
    assign wr_idx      = glb.glb_write_addr_i[ADDR_W-1:2];
    assign rd_in_range = rd_idx < DEPTH_IDX;
    assign wr_in_range = wr_idx < DEPTH_IDX;

    // A write blocked for DRAIN_LIMIT reads takes the port ahead of the next read
    assign force_drain = wb_valid_q && (stall_cnt_q == LIMIT);
    assign glb.glb_read_ready_o  = !force_drain;
    assign rd_acc      = glb.glb_read_i && !force_drain;
    // A full buffer can only take a new write in a cycle where it drains
    assign glb.glb_write_ready_o = !wb_valid_q || !rd_acc;
    assign wr_acc      = glb.glb_write_i && glb.glb_write_ready_o;
    assign drain       = wb_valid_q && !rd_acc;
    assign wr_capture  = wr_acc && wr_in_range && (glb.glb_write_web_i != 4'hF);

    // Next state of the write buffer, stall counter and read-return bookkeeping
    always_comb begin
        wb_valid_d  = wb_valid_q;
        wb_idx_d    = wb_idx_q;
        wb_data_d   = wb_data_q;
        wb_web_d    = wb_web_q;
        stall_cnt_d = stall_cnt_q;
        fwd_mask_d  = fwd_mask_q;
        fwd_data_d  = fwd_data_q;
        rd_zero_d   = rd_zero_q;
        addr_err_d  = addr_err_q;

        if (wr_capture) begin
            wb_valid_d = 1'b1;
            wb_idx_d   = wr_idx[MEM_AW-1:0];
            wb_data_d  = glb.glb_write_data_i;
            wb_web_d   = glb.glb_write_web_i;
        end else if (drain) begin
            wb_valid_d = 1'b0;
        end

        if (!wb_valid_q || drain) begin
            stall_cnt_d = 4'd0;
        end else if (rd_acc && (stall_cnt_q != LIMIT)) begin
            stall_cnt_d = stall_cnt_q + 4'd1;
        end

        // Forwarding uses the buffer contents before this edge, so a same-cycle write stays invisible
        if (rd_acc) begin
            rd_zero_d  = !rd_in_range;
            fwd_data_d = wb_data_q;
            if (rd_in_range && wb_valid_q && (wb_idx_q == rd_idx[MEM_AW-1:0])) begin
                fwd_mask_d = ~wb_web_q;
            end else begin
                fwd_mask_d = 4'h0;
            end
        end

        if ((rd_acc && !rd_in_range) || (wr_acc && !wr_in_range)) begin
            addr_err_d = 1'b1;
        end
    end

    // Control and status registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wb_valid_q  <= 1'b0;
            wb_idx_q    <= '0;
            wb_data_q   <= '0;
            wb_web_q    <= 4'hF;
            stall_cnt_q <= 4'd0;
            fwd_mask_q  <= 4'h0;
            fwd_data_q  <= '0;
            rd_zero_q   <= 1'b1;
            rd_valid_q  <= 1'b0;
            addr_err_q  <= 1'b0;
        end else begin
            wb_valid_q  <= wb_valid_d;
            wb_idx_q    <= wb_idx_d;
            wb_data_q   <= wb_data_d;
            wb_web_q    <= wb_web_d;
            stall_cnt_q <= stall_cnt_d;
            fwd_mask_q  <= fwd_mask_d;
            fwd_data_q  <= fwd_data_d;
            rd_zero_q   <= rd_zero_d;
            rd_valid_q  <= rd_acc;
            addr_err_q  <= addr_err_d;
        end
    end

    // Single memory port: accepted read first, otherwise drain the buffered bytes
    always_ff @(posedge clk) begin
        if (rd_acc) begin
            if (rd_in_range) begin
                mem_rdata_q <= mem[rd_idx[MEM_AW-1:0]];
            end
        end else if (drain) begin
            for (int k = 0; k < 4; k++) begin
                if (!wb_web_q[k]) begin
                    mem[wb_idx_q][8*k +: 8] <= wb_data_q[8*k +: 8];
                end
            end
        end
    end

    // Merge buffered bytes over the memory word; zero after reset or an out-of-range read
    always_comb begin
        glb.glb_read_data_o = '0;
        if (!rd_zero_q) begin
            for (int k = 0; k < 4; k++) begin
                glb.glb_read_data_o[8*k +: 8] = fwd_mask_q[k] ? fwd_data_q[8*k +: 8]
                                                              : mem_rdata_q[8*k +: 8];
            end
        end
    end

    assign glb.glb_read_valid_o = rd_valid_q;
    assign busy_o               = wb_valid_q;
    assign addr_err_o           = addr_err_q;

    // Byte-lane address bits carry no meaning for a word memory
    logic unused_addr_bits;
    assign unused_addr_bits = ^{glb.glb_read_addr_i[1:0], glb.glb_write_addr_i[1:0]};
endmodule

// File: tb/tb_glb_responder.sv
module tb_glb_responder;
    logic clk;
    logic rst_n;
    logic busy_o;
    logic addr_err_o;
    int   n_chk;
    int   n_fail;

    glb_responder_if #(.ADDR_W(32)) bus ();

    glb_responder #(.DEPTH(16384), .ADDR_W(32), .DRAIN_LIMIT(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .glb        (bus),
        .busy_o     (busy_o),
        .addr_err_o (addr_err_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Advance to just after the next rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_rd(input logic en, input logic [31:0] addr);
        bus.glb_read_i      = en;
        bus.glb_read_addr_i = addr;
    endtask

    task automatic set_wr(input logic en, input logic [31:0] addr, input logic [31:0] data,
                          input logic [3:0] web);
        bus.glb_write_i      = en;
        bus.glb_write_addr_i = addr;
        bus.glb_write_data_i = data;
        bus.glb_write_web_i  = web;
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_rvalid"}, {31'd0, bus.glb_read_valid_o}, 32'd0);
        chk({tag, "_rdata"},  bus.glb_read_data_o,           32'd0);
        chk({tag, "_busy"},   {31'd0, busy_o},               32'd0);
        chk({tag, "_err"},    {31'd0, addr_err_o},           32'd0);
        chk({tag, "_rrdy"},   {31'd0, bus.glb_read_ready_o},  32'd1);
        chk({tag, "_wrdy"},   {31'd0, bus.glb_write_ready_o}, 32'd1);
    endtask

    initial begin
        n_chk  = 0;
        n_fail = 0;
        rst_n  = 1'b0;
        set_rd(1'b0, 32'h0);
        set_wr(1'b0, 32'h0, 32'h0, 4'hF);
        #1;
        chk_reset_state("rst");
        tick();
        tick();
        rst_n = 1'b1;
        tick();

        // Plain write then read, forwarding while still buffered, then from memory
        set_wr(1'b1, 32'h10, 32'hAABBCCDD, 4'h0);
        #1 chk("t1_wrdy", {31'd0, bus.glb_write_ready_o}, 32'd1);
        tick();
        chk("t1_busy1", {31'd0, busy_o}, 32'd1);
        set_wr(1'b0, 32'h0, 32'h0, 4'hF);
        set_rd(1'b1, 32'h10);
        tick();
        chk("t1_rvalid", {31'd0, bus.glb_read_valid_o}, 32'd1);
        chk("t1_rdata",  bus.glb_read_data_o, 32'hAABBCCDD);
        set_rd(1'b0, 32'h0);
        tick();
        chk("t1_busy0",   {31'd0, busy_o}, 32'd0);
        chk("t1_rvalid0", {31'd0, bus.glb_read_valid_o}, 32'd0);
        chk("t1_hold",    bus.glb_read_data_o, 32'hAABBCCDD);
        set_rd(1'b1, 32'h10);
        tick();
        chk("t1_memrd", bus.glb_read_data_o, 32'hAABBCCDD);
        set_rd(1'b0, 32'h0);

        // Partial write forwarding and forced drain after DRAIN_LIMIT blocked cycles
        set_wr(1'b1, 32'h10, 32'h11223344, 4'h0);
        tick();
        set_wr(1'b0, 32'h0, 32'h0, 4'hF);
        tick();
        set_wr(1'b1, 32'h10, 32'hFFFFFFFF, 4'b1100);
        tick();
        set_wr(1'b0, 32'h0, 32'h0, 4'hF);
        set_rd(1'b1, 32'h10);
        for (int i = 0; i < 4; i++) begin
            #1 chk($sformatf("t2_rrdy%0d", i), {31'd0, bus.glb_read_ready_o}, 32'd1);
            tick();
            chk($sformatf("t2_fwd%0d", i), bus.glb_read_data_o, 32'h1122FFFF);
        end
        #1 chk("t2_force_rrdy", {31'd0, bus.glb_read_ready_o}, 32'd0);
        chk("t2_force_busy", {31'd0, busy_o}, 32'd1);
        tick();
        chk("t2_drain_valid", {31'd0, bus.glb_read_valid_o}, 32'd0);
        chk("t2_drain_busy",  {31'd0, busy_o}, 32'd0);
        #1 chk("t2_rrdy_back", {31'd0, bus.glb_read_ready_o}, 32'd1);
        tick();
        chk("t2_memrd", bus.glb_read_data_o, 32'h1122FFFF);
        set_rd(1'b0, 32'h0);

        // Read-before-write in the same cycle
        set_wr(1'b1, 32'h20, 32'h0, 4'h0);
        tick();
        set_wr(1'b0, 32'h0, 32'h0, 4'hF);
        tick();
        set_rd(1'b1, 32'h20);
        set_wr(1'b1, 32'h20, 32'h5, 4'h0);
        #1 chk("t3_wrdy", {31'd0, bus.glb_write_ready_o}, 32'd1);
        tick();
        chk("t3_old", bus.glb_read_data_o, 32'h0);
        set_wr(1'b0, 32'h0, 32'h0, 4'hF);
        tick();
        chk("t3_new", bus.glb_read_data_o, 32'h5);
        set_rd(1'b0, 32'h0);
        tick();

        // Full buffer with reads pending: second write waits, enters on the forced drain
        set_wr(1'b1, 32'h30, 32'h0A0A0A0A, 4'h0);
        tick();
        set_rd(1'b1, 32'h10);
        set_wr(1'b1, 32'h34, 32'h0B0B0B0B, 4'h0);
        for (int i = 0; i < 4; i++) begin
            #1 chk($sformatf("t4_wrdy%0d", i), {31'd0, bus.glb_write_ready_o}, 32'd0);
            tick();
        end
        #1 chk("t4_force_rrdy", {31'd0, bus.glb_read_ready_o}, 32'd0);
        chk("t4_force_wrdy", {31'd0, bus.glb_write_ready_o}, 32'd1);
        tick();
        chk("t4_busy_refill", {31'd0, busy_o}, 32'd1);
        set_wr(1'b0, 32'h0, 32'h0, 4'hF);
        set_rd(1'b1, 32'h34);
        tick();
        chk("t4_fwd_b", bus.glb_read_data_o, 32'h0B0B0B0B);
        set_rd(1'b1, 32'h30);
        tick();
        chk("t4_mem_a", bus.glb_read_data_o, 32'h0A0A0A0A);
        set_rd(1'b0, 32'h0);
        tick();
        set_rd(1'b1, 32'h34);
        tick();
        chk("t4_mem_b", bus.glb_read_data_o, 32'h0B0B0B0B);
        set_rd(1'b0, 32'h0);

        // Out-of-range accesses and fully masked writes
        set_wr(1'b1, 32'h0, 32'h12345678, 4'h0);
        tick();
        set_wr(1'b0, 32'h0, 32'h0, 4'hF);
        tick();
        chk("t5_err_clear", {31'd0, addr_err_o}, 32'd0);
        set_rd(1'b1, 32'h0001_0000);
        tick();
        chk("t5_oor_valid", {31'd0, bus.glb_read_valid_o}, 32'd1);
        chk("t5_oor_data",  bus.glb_read_data_o, 32'h0);
        chk("t5_oor_err",   {31'd0, addr_err_o}, 32'd1);
        set_rd(1'b1, 32'h10);
        tick();
        chk("t5_after_data", bus.glb_read_data_o, 32'h1122FFFF);
        chk("t5_err_sticky", {31'd0, addr_err_o}, 32'd1);
        set_rd(1'b0, 32'h0);
        set_wr(1'b1, 32'h0001_0000, 32'hDEADBEEF, 4'h0);
        #1 chk("t5_oorw_wrdy", {31'd0, bus.glb_write_ready_o}, 32'd1);
        tick();
        chk("t5_oorw_busy", {31'd0, busy_o}, 32'd0);
        set_wr(1'b1, 32'h0, 32'h0, 4'hF);
        tick();
        chk("t5_webf_busy", {31'd0, busy_o}, 32'd0);
        set_wr(1'b0, 32'h0, 32'h0, 4'hF);
        set_rd(1'b1, 32'h0);
        tick();
        chk("t5_mem0", bus.glb_read_data_o, 32'h12345678);
        set_rd(1'b0, 32'h0);

        // Reset while a write is buffered discards it
        set_wr(1'b1, 32'h0, 32'hCAFEF00D, 4'h0);
        tick();
        chk("t6_busy", {31'd0, busy_o}, 32'd1);
        set_wr(1'b0, 32'h0, 32'h0, 4'hF);
        #2 rst_n = 1'b0;
        #1;
        chk_reset_state("t6_rst");
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        set_rd(1'b1, 32'h0);
        tick();
        chk("t6_not_committed", bus.glb_read_data_o, 32'h12345678);
        set_rd(1'b0, 32'h0);
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
